frv_bdram_dp: RTL and testbench
===============================

Name: frv_bdram_dp

Overview:
- Parametrised dual-port, byte-write block RAM. Next generation of the single-port 64-bit data RAM.
- Port A is read-only and serves instruction fetch. Port B is read/write with byte enables and serves load/store.
- Both ports use valid/ready request and response handshakes, with a one-cycle registered read and a held response.
- Sits between the CPU core (or AXI slave shim) and on-chip memory.

Parameters:
- DATA_W, 64, word width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width; depth = 2**ADDR_W words.
- BE_W, DATA_W/8, byte-enable width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- a_req_valid  in  1  port A read request valid.
- a_req_ready  out  1  port A can accept a request.
- a_addr  in  ADDR_W  port A word address.
- a_rsp_valid  out  1  port A read data valid.
- a_rsp_ready  in  1  port A consumer accepts the response.
- a_rdata  out  DATA_W  port A read data.
- b_req_valid  in  1  port B request valid.
- b_req_ready  out  1  port B can accept a request.
- b_addr  in  ADDR_W  port B word address.
- b_wen  in  BE_W  byte write enables; all-zero means a read.
- b_wdata  in  DATA_W  port B write data.
- b_rsp_valid  out  1  port B response valid.
- b_rsp_ready  in  1  port B consumer accepts the response.
- b_rdata  out  DATA_W  port B response data.

Behaviour:
- Reset: a_rsp_valid=0, b_rsp_valid=0, a_rdata=0, b_rdata=0. Memory array is not cleared. Reset mid-operation drops pending responses. No array write occurs on an edge where resetn=0.
- Ready rule, per port independently: x_req_ready = !x_rsp_valid || x_rsp_ready. This is combinational; there are no other stalls.
- Accept: a request is accepted when x_req_valid && x_req_ready at a rising edge.
- Latency: a request accepted at edge N gives x_rsp_valid=1 with its data from edge N, visible in cycle N+1.
- Hold: if x_rsp_valid && !x_rsp_ready, x_rdata and x_rsp_valid hold stable and no new request is accepted.
- Clear: when the response is accepted and no new request is accepted in the same cycle, x_rsp_valid drops to 0. x_rdata holds its last value.
- Back-to-back: a response accepted in the same cycle as a new request gives 1 request/cycle throughput with x_rsp_valid held at 1.
- Port B read: b_rdata = mem[b_addr].
- Port B write: for each byte i with b_wen[i]=1, the byte is replaced by b_wdata; other bytes are kept. b_rdata = the merged word now stored in the array (write-first).
- Collision, A read and B write to the same address accepted at the same edge: A returns the pre-write word (read-first), unless the optional feature below is compiled in.
- Same-address B accesses on consecutive cycles see the earlier write. There is no hazard window.
- Address: the full 2**ADDR_W range is valid; there is no out-of-range case.

Optional Feature:
- Macro: FRV_BDRAM_COLLISION_BYPASS_EN.
- Defined: on an A/B same-address collision, a_rdata returns the merged post-write word, identical to b_rdata.
- Undefined: A returns the pre-write word, as described above.
- Either way, the stored result is identical.

Decomposition:
- Package frv_bdram_pkg holds:
  - defaults DATA_W=64 and ADDR_W=16;
  - a function computing BE_W;
  - a byte-merge function (old, new, be) -> word, shared with the future AXI shim.
- One sub-module, frv_bdram_rsp_slot:
  - contains the response register, valid flag and ready logic;
  - parametrised by DATA_W;
  - instantiated once per port.

Test Plan:
- Reset, then B write addr 0x0010, wen=0xFF, wdata=0x1122334455667788 -> next cycle b_rsp_valid=1, b_rdata=0x1122334455667788. A read of 0x0010 returns the same value one cycle after acceptance.
- Partial write to addr 0x0010 with wen=0x0F, wdata=0xAAAAAAAA_BBBBBBBB -> b_rdata and a later B read both return 0x11223344_BBBBBBBB.
- Backpressure: A reads 0x0010 with a_rsp_ready=0 for 3 cycles -> a_rsp_valid and a_rdata stay stable and a_req_ready=0 throughout. When ready rises, a queued read of 0x0011 is accepted that same cycle, with no gap.
- Collision: A read and B write (wen=0xFF, wdata=0xDEADBEEFCAFEF00D) both accepted on addr 0x0020, which holds 0x0 -> a_rdata=0x0 without the macro, 0xDEADBEEFCAFEF00D with FRV_BDRAM_COLLISION_BYPASS_EN.
- Reset mid-flight: assert resetn=0 while b_rsp_valid=1 and a B write to 0x0030 is presented -> both rsp_valid=0 and both rdata=0 immediately. After release, 0x0030 still holds its prior contents.
- Streaming: 256 back-to-back B writes then 256 back-to-back A reads with both ready held high -> one response per cycle, all data matching a scoreboard.

Source files
------------

// File: rtl/frv_bdram_pkg.sv
// frv_bdram_pkg -- shared definitions for the dual-port byte-write data RAM.
//   DATA_W_DEF / ADDR_W_DEF : default word width and word-address width.
//   calc_be_w()             : byte-enable width for a given data width.
//   byte_merge()            : merges new bytes into an old word under a byte
//                             enable mask. It works at MERGE_MAX_W bits, so
//                             callers zero-extend their inputs and truncate
//                             the result. This lets one function serve any
//                             width up to that limit (RAM and AXI shim).
package frv_bdram_pkg;

    localparam int DATA_W_DEF   = 64;
    localparam int ADDR_W_DEF   = 16;
    localparam int MERGE_MAX_W  = 1024;
    localparam int MERGE_MAX_BE = MERGE_MAX_W / 8;

    function automatic int calc_be_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]  old_w,
        input logic [MERGE_MAX_W-1:0]  new_w,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_w;
        for (int i = 0; i < MERGE_MAX_BE; i++) begin
            if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/frv_bdram_rsp_slot.sv
// frv_bdram_rsp_slot -- one-entry response register with valid/ready handshake.
//   clk, resetn  : clock and asynchronous active-low reset
//   req_valid    : upstream request valid
//   req_ready    : slot can take a request (empty, or draining this cycle)
//   req_accept   : request accepted at the coming edge
//   load_data    : response data to capture when a request is accepted
//   rsp_valid    : response held in the slot
//   rsp_ready    : consumer accepts the response
//   rsp_data     : held response data; it keeps its last value after draining
module frv_bdram_rsp_slot
    import frv_bdram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    output logic              req_accept,
    input  logic [DATA_W-1:0] load_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data
);

    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;

    always_comb begin
        // A draining response frees the slot in the same cycle, which
        // gives one request per cycle when the consumer is always ready.
        req_ready   = !rsp_valid_q || rsp_ready;
        req_accept  = req_valid && req_ready;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        if (req_accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = load_data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: rtl/frv_bdram.sv
// frv_bdram_dp -- dual-port byte-write block RAM.
//   Port A (a_*) : read-only, used for instruction fetch.
//   Port B (b_*) : read/write with byte enables, used for load/store.
//                  b_wen == 0 is a read. For a write the response carries
//                  the merged word as stored (write-first).
//   Both ports use valid/ready requests, a one-cycle registered read and a
//   held response.
//   Optional macro FRV_BDRAM_COLLISION_BYPASS_EN: when A and B access the same
//   address and B writes at that edge, A returns the merged post-write word.
//   Without the macro, A returns the pre-write word (read-first).
//   The stored result is the same either way.
module frv_bdram_dp
    import frv_bdram_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int ADDR_W = ADDR_W_DEF,
    localparam int BE_W   = calc_be_w(DATA_W)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_rsp_valid,
    input  logic              a_rsp_ready,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [BE_W-1:0]   b_wen,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rsp_valid,
    input  logic              b_rsp_ready,
    output logic [DATA_W-1:0] b_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              a_acc, b_acc;
    logic              b_is_wr;
    logic [DATA_W-1:0] b_merged;
    logic [DATA_W-1:0] a_load_d, b_load_d;

    always_comb begin
        b_is_wr  = |b_wen;
        // With b_wen == 0 the merge returns the old word, so a read and
        // a write share the same response path.
        b_merged = DATA_W'(byte_merge(MERGE_MAX_W'(mem_q[b_addr]),
                                      MERGE_MAX_W'(b_wdata),
                                      MERGE_MAX_BE'(b_wen)));
        b_load_d = b_merged;
        a_load_d = mem_q[a_addr];
`ifdef FRV_BDRAM_COLLISION_BYPASS_EN
        if (b_acc && b_is_wr && (a_addr == b_addr)) a_load_d = b_merged;
`else
        // Read-first: A always gets the array contents from before the edge.
`endif
    end

    // Per-byte write lanes keep the array mappable onto byte-write block RAM.
    // Writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (resetn && b_acc && b_is_wr) begin
            for (int i = 0; i < BE_W; i++) begin
                if (b_wen[i]) mem_q[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
            end
        end
    end

    frv_bdram_rsp_slot #(.DATA_W(DATA_W)) u_a_slot (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (a_req_valid),
        .req_ready  (a_req_ready),
        .req_accept (a_acc),
        .load_data  (a_load_d),
        .rsp_valid  (a_rsp_valid),
        .rsp_ready  (a_rsp_ready),
        .rsp_data   (a_rdata)
    );

    frv_bdram_rsp_slot #(.DATA_W(DATA_W)) u_b_slot (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_accept (b_acc),
        .load_data  (b_load_d),
        .rsp_valid  (b_rsp_valid),
        .rsp_ready  (b_rsp_ready),
        .rsp_data   (b_rdata)
    );

endmodule

// File: tb/tb_frv_bdram_dp.sv
// tb_frv_bdram_dp -- directed self-checking bench for frv_bdram_dp.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that
// same point, away from the edge.
module tb_frv_bdram_dp;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 16;
    localparam int BE_W   = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic              a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_rdata;
    logic              b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [BE_W-1:0]   b_wen;
    logic [DATA_W-1:0] b_wdata, b_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    frv_bdram_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .a_req_valid (a_req_valid),
        .a_req_ready (a_req_ready),
        .a_addr      (a_addr),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_ready (a_rsp_ready),
        .a_rdata     (a_rdata),
        .b_req_valid (b_req_valid),
        .b_req_ready (b_req_ready),
        .b_addr      (b_addr),
        .b_wen       (b_wen),
        .b_wdata     (b_wdata),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_ready (b_rsp_ready),
        .b_rdata     (b_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single B transaction: present for one edge, then drop valid.
    task automatic b_op(input logic [15:0] addr, input logic [7:0] wen, input logic [63:0] wd);
        b_req_valid = 1'b1; b_addr = addr; b_wen = wen; b_wdata = wd;
        step();
        b_req_valid = 1'b0; b_wen = '0;
    endtask

    task automatic a_op(input logic [15:0] addr);
        a_req_valid = 1'b1; a_addr = addr;
        step();
        a_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        step(); step();
        n_tests++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_rsp_valid got=%b exp=0", a_rsp_valid); end
        n_tests++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_rsp_valid got=%b exp=0", b_rsp_valid); end
        n_tests++; if (a_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_a_rdata got=%h exp=0", a_rdata); end
        n_tests++; if (b_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_b_rdata got=%h exp=0", b_rdata); end
        n_tests++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b%b exp=11", a_req_ready, b_req_ready); end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_full_write();
        b_op(16'h0010, 8'hFF, 64'h1122334455667788);
        n_tests++; if (b_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_b_rsp_valid got=%b exp=1", b_rsp_valid); end
        n_tests++; if (b_rdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL wr_b_rdata got=%h exp=1122334455667788", b_rdata); end
        step();
        n_tests++; if (b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL wr_b_rsp_clear got=%b exp=0", b_rsp_valid); end
        n_tests++; if (b_rdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL wr_b_rdata_hold got=%h exp=1122334455667788", b_rdata); end
        a_op(16'h0010);
        n_tests++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd_a_rsp_valid got=%b exp=1", a_rsp_valid); end
        n_tests++; if (a_rdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL rd_a_rdata got=%h exp=1122334455667788", a_rdata); end
        step();
        n_tests++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_a_rsp_clear got=%b exp=0", a_rsp_valid); end
    endtask

    task automatic test_partial_write();
        // Write immediately followed by a read of the same address.
        b_req_valid = 1'b1; b_addr = 16'h0010; b_wen = 8'h0F; b_wdata = 64'hAAAAAAAABBBBBBBB;
        step();
        n_tests++; if (b_rdata !== 64'h11223344BBBBBBBB) begin n_fail++; $display("FAIL part_wr_rdata got=%h exp=11223344bbbbbbbb", b_rdata); end
        b_wen = 8'h00; b_wdata = 64'hFFFFFFFFFFFFFFFF;
        step();
        b_req_valid = 1'b0;
        n_tests++; if (b_rsp_valid !== 1'b1 || b_rdata !== 64'h11223344BBBBBBBB) begin n_fail++; $display("FAIL part_rd_rdata got=%b/%h exp=1/11223344bbbbbbbb", b_rsp_valid, b_rdata); end
        step();
    endtask

    task automatic test_consecutive_bytes();
        b_req_valid = 1'b1; b_addr = 16'h0040;
        b_wen = 8'hFF; b_wdata = 64'h0;                step();
        b_wen = 8'h01; b_wdata = 64'h00000000000000FF; step();
        n_tests++; if (b_rdata !== 64'h00000000000000FF) begin n_fail++; $display("FAIL b2b_wr1 got=%h exp=00000000000000ff", b_rdata); end
        b_wen = 8'h80; b_wdata = 64'hAB00000000000000; step();
        n_tests++; if (b_rdata !== 64'hAB000000000000FF) begin n_fail++; $display("FAIL b2b_wr2 got=%h exp=ab000000000000ff", b_rdata); end
        b_wen = 8'h00; step();
        b_req_valid = 1'b0;
        n_tests++; if (b_rsp_valid !== 1'b1 || b_rdata !== 64'hAB000000000000FF) begin n_fail++; $display("FAIL b2b_rd got=%b/%h exp=1/ab000000000000ff", b_rsp_valid, b_rdata); end
        step();
    endtask

    task automatic test_backpressure();
        b_op(16'h0011, 8'hFF, 64'h0102030405060708);
        a_rsp_ready = 1'b0;
        a_req_valid = 1'b1; a_addr = 16'h0010;
        step();
        a_addr = 16'h0011;  // queued request held while stalled
        for (int c = 0; c < 3; c++) begin
            n_tests++; if (a_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_c%0d got=%b exp=1", c, a_rsp_valid); end
            n_tests++; if (a_rdata !== 64'h11223344BBBBBBBB) begin n_fail++; $display("FAIL bp_rdata_c%0d got=%h exp=11223344bbbbbbbb", c, a_rdata); end
            n_tests++; if (a_req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready_c%0d got=%b exp=0", c, a_req_ready); end
            if (c < 2) step();
        end
        a_rsp_ready = 1'b1;
        #1;
        n_tests++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got=%b exp=1", a_req_ready); end
        step();
        a_req_valid = 1'b0;
        n_tests++; if (a_rsp_valid !== 1'b1 || a_rdata !== 64'h0102030405060708) begin n_fail++; $display("FAIL bp_next_rd got=%b/%h exp=1/0102030405060708", a_rsp_valid, a_rdata); end
        step();
        n_tests++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_clear got=%b exp=0", a_rsp_valid); end
    endtask

    task automatic test_collision();
        logic [63:0] exp_a;
`ifdef FRV_BDRAM_COLLISION_BYPASS_EN
        exp_a = 64'hDEADBEEFCAFEF00D;
`else
        exp_a = 64'h0;
`endif
        b_op(16'h0020, 8'hFF, 64'h0);
        step();
        a_req_valid = 1'b1; a_addr = 16'h0020;
        b_req_valid = 1'b1; b_addr = 16'h0020; b_wen = 8'hFF; b_wdata = 64'hDEADBEEFCAFEF00D;
        step();
        a_req_valid = 1'b0; b_req_valid = 1'b0; b_wen = '0;
        n_tests++; if (b_rdata !== 64'hDEADBEEFCAFEF00D) begin n_fail++; $display("FAIL coll_b_rdata got=%h exp=deadbeefcafef00d", b_rdata); end
        n_tests++; if (a_rsp_valid !== 1'b1 || a_rdata !== exp_a) begin n_fail++; $display("FAIL coll_a_rdata got=%b/%h exp=1/%h", a_rsp_valid, a_rdata, exp_a); end
        step();
        a_op(16'h0020);
        n_tests++; if (a_rdata !== 64'hDEADBEEFCAFEF00D) begin n_fail++; $display("FAIL coll_stored got=%h exp=deadbeefcafef00d", a_rdata); end
        step();
    endtask

    task automatic test_reset_midflight();
        b_op(16'h0030, 8'hFF, 64'h5555666677778888);
        a_req_valid = 1'b1; a_addr = 16'h0030;
        b_req_valid = 1'b1; b_addr = 16'h0030; b_wen = 8'h00;
        step();
        a_req_valid = 1'b0;
        n_tests++; if (a_rsp_valid !== 1'b1 || b_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got=%b%b exp=11", a_rsp_valid, b_rsp_valid); end
        b_wen = 8'hFF; b_wdata = 64'h9999999999999999;
        resetn = 1'b0;
        #1;
        n_tests++; if (a_rsp_valid !== 1'b0 || b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b%b exp=00", a_rsp_valid, b_rsp_valid); end
        n_tests++; if (a_rdata !== 64'h0 || b_rdata !== 64'h0) begin n_fail++; $display("FAIL mid_rst_rdata got=%h/%h exp=0/0", a_rdata, b_rdata); end
        step(); step();
        b_req_valid = 1'b0; b_wen = '0;
        resetn = 1'b1;
        step();
        a_op(16'h0030);
        n_tests++; if (a_rdata !== 64'h5555666677778888) begin n_fail++; $display("FAIL mid_mem_kept got=%h exp=5555666677778888", a_rdata); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [63:0] sb [256];
        for (int i = 0; i < 256; i++) sb[i] = {8'(i), 24'hC0FFEE, 16'(~i), 16'(i * 3)};
        b_req_valid = 1'b1; b_wen = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            b_addr = 16'h0100 + 16'(i); b_wdata = sb[i];
            step();
            n_tests++; if (b_rsp_valid !== 1'b1 || b_rdata !== sb[i]) begin n_fail++; $display("FAIL stream_wr_%0d got=%b/%h exp=1/%h", i, b_rsp_valid, b_rdata, sb[i]); end
        end
        b_req_valid = 1'b0; b_wen = '0;
        step();
        a_req_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a_addr = 16'h0100 + 16'(i);
            step();
            n_tests++; if (a_rsp_valid !== 1'b1 || a_rdata !== sb[i]) begin n_fail++; $display("FAIL stream_rd_%0d got=%b/%h exp=1/%h", i, a_rsp_valid, a_rdata, sb[i]); end
        end
        a_req_valid = 1'b0;
        step();
    endtask

    initial begin
        resetn = 1'b0;
        a_req_valid = 1'b0; a_addr = '0; a_rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_addr = '0; b_wen = '0; b_wdata = '0; b_rsp_ready = 1'b1;
        test_reset();
        test_full_write();
        test_partial_write();
        test_consecutive_bytes();
        test_backpressure();
        test_collision();
        test_reset_midflight();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
